// File: rtl/id_scoreboard_if.sv
// Decode/write-back bundle between decode and the register hazard scoreboard.
// master: decode side drives instruction/WB fields; slave: scoreboard drives stall/issue/status.
interface id_scoreboard_if;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic        id_rs_used;
  logic [4:0]  id_rt;
  logic        id_rt_used;
  logic [4:0]  id_rd;
  logic        id_writes;
  logic        id_sp_update;
  logic        ex_ready;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic        stall;
  logic        issue;
  logic [31:0] pending;
  logic [15:0] stall_count;
  logic        hazard_timeout;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
    output id_rd, id_writes, id_sp_update, ex_ready, flush,
    output wb_valid, wb_reg,
    input  stall, issue, pending, stall_count, hazard_timeout
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
    input  id_rd, id_writes, id_sp_update, ex_ready, flush,
    input  wb_valid, wb_reg,
    output stall, issue, pending, stall_count, hazard_timeout
  );
endinterface

// File: rtl/id_scoreboard.sv
// RAW/WAW register hazard scoreboard: stalls decode on pending regs, releases on WB.
// Ports: clk, rst (sync, high), sb (slave: decode fields, WB, stall/issue/status).
module id_scoreboard #(
  parameter int SP_REG    = 29,
  parameter int WB_BYPASS = 0,
  parameter int TIMEOUT   = 1023
) (
  input logic clk,
  input logic rst,
  id_scoreboard_if.slave sb
);

  localparam int RW = (TIMEOUT > 1023) ? $clog2(TIMEOUT + 1) : 10;
  localparam logic [RW-1:0] RUN_MAX = RW'(TIMEOUT);
  localparam logic [RW-1:0] RUN_SET = RW'(TIMEOUT - 1);

  logic [31:0]   pend_q;
  logic [31:0]   pend_d;
  logic [31:0]   rd_mask;
  logic [31:0]   wr_mask;
  logic [31:0]   wb_mask;
  logic [31:0]   busy;
  logic          hazard;
  logic          stall;
  logic          issue;
  logic [15:0]   cnt_q;
  logic [RW-1:0] run_q;
  logic          to_q;

  always_comb begin
    rd_mask = '0;
    wr_mask = '0;
    wb_mask = '0;
    if (sb.id_rs_used) rd_mask[sb.id_rs] = 1'b1;
    if (sb.id_rt_used) rd_mask[sb.id_rt] = 1'b1;
    if (sb.id_writes)  wr_mask[sb.id_rd] = 1'b1;
    if (sb.id_sp_update) begin
      rd_mask[SP_REG] = 1'b1;
      wr_mask[SP_REG] = 1'b1;
    end
    if (sb.wb_valid) wb_mask[sb.wb_reg] = 1'b1;
    // r0 is hardwired: never tracked, never a hazard
    rd_mask[0] = 1'b0;
    wr_mask[0] = 1'b0;
    // write-through lets a retiring reg unblock in its WB cycle
    busy   = (WB_BYPASS != 0) ? (pend_q & ~wb_mask) : pend_q;
    hazard = |((rd_mask | wr_mask) & busy);
    stall  = sb.id_valid & ~sb.flush & (hazard | ~sb.ex_ready);
    issue  = sb.id_valid & ~sb.flush & ~hazard & sb.ex_ready;
    // clear first, then set: a same-reg issue keeps the bit
    pend_d = pend_q & ~wb_mask;
    if (issue) pend_d = pend_d | wr_mask;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
      run_q  <= '0;
      to_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (stall && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
      if (stall) begin
        if (run_q != RUN_MAX) run_q <= run_q + 1'b1;
        if (run_q == RUN_SET) to_q <= 1'b1;
      end else begin
        run_q <= '0;
      end
    end
  end

  assign sb.stall          = stall;
  assign sb.issue          = issue;
  assign sb.pending        = pend_q;
  assign sb.stall_count    = cnt_q;
  assign sb.hazard_timeout = to_q;

endmodule

// File: doc/id_scoreboard.md
# id_scoreboard

Register-file hazard controller for the decode stage. It tracks which of the 32 RegFile registers have a write in flight. It stalls decode when an instruction reads or re-writes a pending register (RAW/WAW). It issues the instruction otherwise and releases registers as write-back retires them. It sits beside the decode unit, consumes decoded register fields plus the write-back port, and drives the pipeline stall/issue handshake.

## Interface
Parameters:
- SP_REG, 29: register index used implicitly by CALL/RET/PUSH/POP.
- WB_BYPASS, 0: 1 = a write-back retiring register X in cycle N clears X's hazard in cycle N (RegFile write-through); 0 = clear is visible from cycle N+1.
- TIMEOUT, 1023: consecutive stall cycles after which hazard_timeout is raised.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  decode holds a valid instruction.
- id_rs  in  5  first source register.
- id_rs_used  in  1  id_rs is read.
- id_rt  in  5  second source register (rt or rd per reg_2_sel).
- id_rt_used  in  1  id_rt is read.
- id_rd  in  5  destination register.
- id_writes  in  1  instruction writes id_rd (RegWrite or pop).
- id_sp_update  in  1  CALL/RET/PUSH/POP: reads and writes SP_REG.
- ex_ready  in  1  downstream stage can accept an instruction this cycle.
- flush  in  1  squash the decode instruction (branch redirect).
- wb_valid  in  1  write-back commits this cycle.
- wb_reg  in  5  register written by write-back.
- stall  out  1  hold IF/ID this cycle (combinational).
- issue  out  1  decode instruction advances this cycle (combinational).
- pending  out  32  pending-write bitmap (registered).
- stall_count  out  16  saturating count of stall cycles since reset.
- hazard_timeout  out  1  sticky; set when a stall persists TIMEOUT cycles.

## Operation
- Effective reads: rs if id_rs_used; rt if id_rt_used; SP_REG if id_sp_update.
- Effective write: id_rd if id_writes; SP_REG also if id_sp_update. Either or both may be set.
- Register 0 is the zero register. It is never marked pending and never causes a hazard.
- hazard = any effective read or write register R != 0 with busy(R).
- busy(R) = pending[R], except when WB_BYPASS=1 and wb_valid and wb_reg==R, where busy(R)=0.
- stall = id_valid & !flush & (hazard | !ex_ready).
- issue = id_valid & !flush & !hazard & ex_ready. stall and issue are never both 1.
- Next pending state:
  - clear bit wb_reg when wb_valid;
  - then set the effective write bits when issue.
  - Set wins over clear on the same register, which is only reachable with WB_BYPASS=1.
- Write-back to a non-pending register is ignored; pending is unchanged.
- flush squashes only the decode instruction. Already-issued instructions still retire through write-back, so pending is not cleared by flush.
- stall_count increments on every cycle stall=1 and saturates at 16'hFFFF.
- Stall-run counter (internal, 10+ bits):
  - increments while stall=1 and resets to 0 when stall=0;
  - when it reaches TIMEOUT, hazard_timeout is set and stays 1 until rst.

## Timing
- Reset (rst=1 at an edge): pending=0, stall_count=0, hazard_timeout=0, stall-run counter=0. stall/issue follow inputs combinationally against the reset state.
- Decision latency 0: stall/issue reflect the current-cycle inputs and pending.
- Pending latency 1: a bit set by issue in cycle N is visible in pending and hazard from cycle N+1.
- Write-back visibility: a clear in cycle N is visible in cycle N+1 (WB_BYPASS=0) or in cycle N (WB_BYPASS=1).
- rst asserted mid-stall drops all pending bits and returns to the idle state the next cycle. Instructions in flight at that point are the pipeline's responsibility.

## Test plan
- Reset/idle:
  - Stimulus: rst 1 cycle, then id_valid=1, rs=3, rt=4, rd=5, writes, ex_ready=1.
  - Response: issue=1, stall=0; next cycle pending=32'h0000_0020.
- RAW stall and release (WB_BYPASS=0):
  - Stimulus: issue write r5; next instruction reads rs=5; wb_valid, wb_reg=5 three cycles later.
  - Response: stall=1 for 4 cycles (through the WB cycle), issue on the following cycle, stall_count=4.
- Bypass variant:
  - Stimulus: same as the RAW case with WB_BYPASS=1.
  - Response: issue occurs in the WB cycle; stall_count=3; pending[5] ends 1 if the new instruction writes r5.
- SP ops:
  - Stimulus: PUSH (id_sp_update=1) issues; following POP.
  - Response: POP stalls until wb_reg=29 retires; pending[29] is set/cleared accordingly.
- Zero register / flush:
  - Stimulus: write r0; read r0; flush=1 with a hazard present.
  - Response: pending[0] stays 0; no stall on r0; under flush stall=0, issue=0, pending unchanged.
- Timeout:
  - Stimulus: TIMEOUT=8; hold a RAW hazard with no write-back for 10 cycles, then rst.
  - Response: hazard_timeout rises after the 8th stall cycle, stays high, and clears only on rst.
